pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk.
- drs  in  5  D-stage source register rs.
- drt  in  5  D-stage source register rt.
- duse_rs  in  1  D-stage instruction reads rs.
- duse_rt  in  1  D-stage instruction reads rt.
- ern  in  5  E-stage destination register.
- ewreg  in  1  E-stage writes a register.
- em2reg  in  1  E-stage instruction is a load.
- mrn  in  5  M-stage destination register.
- mwreg  in  1  M-stage writes a register.
- mm2reg  in  1  M-stage instruction is a load.
- eredirect  in  1  E-stage taken branch/jump redirects PC.
- wpcir  out  1  PC and F/D register write enable; 0 holds.
- fd_clear  out  1  squash F/D register.
- de_clear  out  1  clear to D/E register; inserts bubble.
- fwda  out  2  rs operand select: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M load data.
- fwdb  out  2  rt operand select, same encoding as fwda.
- stall_cnt  out  16  saturating count of load-use bubbles.
- flush_cnt  out  16  saturating count of redirect flushes.

Function
REQ-002 wpcir, fd_clear, de_clear, fwda and fwdb SHALL be combinational from the current state and inputs, with zero-cycle latency.
- stall_cnt, flush_cnt and the FSM state SHALL be registered.

REQ-003 Forwarding for rs (fwdb identical with drt):
- priority 1: ewreg=1, ern!=0, ern==drs, em2reg=0 -> 01;
- priority 2: mwreg=1, mrn!=0, mrn==drs -> 11 if mm2reg=1, else 10;
- otherwise -> 00.

REQ-004 Register 0 SHALL never match: ern=0 or mrn=0 never forwards and never stalls.

REQ-005 load_use = ewreg & em2reg & (ern!=0) & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).

REQ-006 The FSM SHALL have two states: RUN and BUBBLE.

REQ-007 In RUN, load_use=1 and eredirect=0:
- outputs: wpcir=0, de_clear=1, fd_clear=0;
- next state: BUBBLE;
- stall_cnt increments.

REQ-008 In BUBBLE, load_use SHALL be masked:
- outputs: wpcir=1, de_clear=0, fd_clear=0;
- next state: RUN unconditionally.
- At most one consecutive bubble is allowed per load; the load now sits in M and forwards via 11.

REQ-009 eredirect=1 in either state:
- outputs: wpcir=1, fd_clear=1, de_clear=1;
- next state: RUN;
- flush_cnt increments;
- eredirect overrides a simultaneous load_use, so stall_cnt does not increment.

REQ-010 No hazard and no redirect: wpcir=1, fd_clear=0, de_clear=0, state holds RUN.

REQ-011 Both counters SHALL saturate at 16'hFFFF with no wrap.

REQ-012 The forwarding outputs SHALL be computed in every state, including during stall and flush cycles.

Reset
REQ-013 While rst_n=0:
- combinational outputs: wpcir=1, fd_clear=1, de_clear=1, fwda=00, fwdb=00, regardless of other inputs;
- at the clock edge: state=RUN, stall_cnt=0, flush_cnt=0.

REQ-014 Reset asserted in BUBBLE SHALL return the FSM to RUN at the next edge with no residual stall.

REQ-015 First edge after rst_n rises: normal operation from RUN.

Verification
REQ-016 Forward priority:
- stimulus: drs=5, ern=5, ewreg=1, em2reg=0, mrn=5, mwreg=1;
- required: fwda=01.
- Then ewreg=0 -> fwda=10; then mm2reg=1 -> fwda=11.

REQ-017 Load-use:
- stimulus: drt=7, duse_rt=1, ern=7, ewreg=1, em2reg=1 in RUN;
- cycle t: wpcir=0, de_clear=1;
- cycle t+1, with inputs held: wpcir=1, de_clear=0, state=RUN;
- stall_cnt=1.

REQ-018 Redirect during load-use:
- stimulus: the REQ-017 inputs plus eredirect=1;
- required: wpcir=1, fd_clear=1, de_clear=1, flush_cnt=1, stall_cnt=0.

REQ-019 Register zero:
- stimulus: drs=0, duse_rs=1, ern=0, ewreg=1, em2reg=1;
- required: fwda=00, wpcir=1, de_clear=0.

REQ-020 Saturation:
- stimulus: preload flush_cnt to 16'hFFFE via repeated eredirect, then apply 3 more redirects;
- required: flush_cnt=16'hFFFF.

REQ-021 Reset mid-stall:
- stimulus: enter BUBBLE, hold rst_n=0 for one edge with load_use inputs active;
- required: de_clear=1, wpcir=1 during reset; counters=0 after it.
- After release with load_use still active: RUN-state stall behaviour, stall_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding select, load-use stall with a
// single bubble, and redirect flush, plus saturating stall/flush event counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duse_rs,
  input  logic        duse_rt,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        eredirect,
  output logic        wpcir,
  output logic        fd_clear,
  output logic        de_clear,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {StRun, StBubble} state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;
  logic        load_use;

  // E-stage loads cannot forward yet; they fall through to the M-stage check.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ewreg && (ern != 5'd0) && (ern == src) && !em2reg) begin
      return 2'b01;
    end else if (mwreg && (mrn != 5'd0) && (mrn == src)) begin
      return mm2reg ? 2'b11 : 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  assign load_use = ewreg && em2reg && (ern != 5'd0) &&
                    ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));

  always_comb begin
    wpcir     = 1'b1;
    fd_clear  = 1'b0;
    de_clear  = 1'b0;
    fwda      = fwd_sel(drs);
    fwdb      = fwd_sel(drt);
    state_d   = state_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!rst_n) begin
      fd_clear = 1'b1;
      de_clear = 1'b1;
      fwda     = 2'b00;
      fwdb     = 2'b00;
      state_d  = StRun;
    end else if (eredirect) begin
      // Redirect wins over a coincident load-use; the stall would be squashed anyway.
      fd_clear  = 1'b1;
      de_clear  = 1'b1;
      state_d   = StRun;
      flush_inc = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            wpcir     = 1'b0;
            de_clear  = 1'b1;
            state_d   = StBubble;
            stall_inc = 1'b1;
          end
        end
        StBubble: begin
          // Load has moved to M and forwards from there; no second bubble.
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_inc && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  drs, drt, ern, mrn;
  logic        duse_rs, duse_rt, ewreg, em2reg, mwreg, mm2reg, eredirect;
  logic        wpcir, fd_clear, de_clear;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt, flush_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  bit m_bubble;
  int m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .drs       (drs),
    .drt       (drt),
    .duse_rs   (duse_rs),
    .duse_rt   (duse_rt),
    .ern       (ern),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .mrn       (mrn),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .eredirect (eredirect),
    .wpcir     (wpcir),
    .fd_clear  (fd_clear),
    .de_clear  (de_clear),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  function automatic int m_fwd(input int src);
    if (ewreg && ern != 0 && int'(ern) == src && !em2reg) return 1;
    if (mwreg && mrn != 0 && int'(mrn) == src) return mm2reg ? 3 : 2;
    return 0;
  endfunction

  function automatic bit m_load_use();
    bit hit_rs, hit_rt;
    hit_rs = duse_rs && ern == drs;
    hit_rt = duse_rt && ern == drt;
    return ewreg && em2reg && ern != 0 && (hit_rs || hit_rt);
  endfunction

  // {wpcir, fd_clear, de_clear, fwda, fwdb}
  function automatic logic [6:0] exp_comb();
    logic [2:0] ctl;
    logic [1:0] a, b;
    a = 2'(m_fwd(int'(drs)));
    b = 2'(m_fwd(int'(drt)));
    if (!rst_n) return 7'b111_00_00;
    if (eredirect) ctl = 3'b111;
    else if (m_load_use() && !m_bubble) ctl = 3'b001;
    else ctl = 3'b100;
    return {ctl, a, b};
  endfunction

  function automatic logic [6:0] obs_comb();
    return {wpcir, fd_clear, de_clear, fwda, fwdb};
  endfunction

  function automatic logic [31:0] exp_cnt();
    return {16'(m_stall), 16'(m_flush)};
  endfunction

  task automatic tick();
    bit lu;
    @(posedge clk);
    lu = m_load_use();
    if (!rst_n) begin
      m_bubble = 0; m_stall = 0; m_flush = 0;
    end else if (eredirect) begin
      m_bubble = 0;
      if (m_flush < 65535) m_flush++;
    end else if (lu && !m_bubble) begin
      m_bubble = 1;
      if (m_stall < 65535) m_stall++;
    end else begin
      m_bubble = 0;
    end
    #1;
  endtask

  task automatic idle();
    rst_n = 1; drs = 0; drt = 0; duse_rs = 0; duse_rt = 0; ern = 0; ewreg = 0;
    em2reg = 0; mrn = 0; mwreg = 0; mm2reg = 0; eredirect = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; drs = 5'd3; drt = 5'd3; duse_rs = 1; ern = 5'd3; ewreg = 1; em2reg = 1;
    mrn = 5'd3; mwreg = 1;
    #1;
    n_total++;
    if (obs_comb() !== 7'b111_00_00)
      $display("FAIL reset_comb: got %b expected %b", obs_comb(), 7'b111_00_00);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if ({stall_cnt, flush_cnt} !== 32'h0)
      $display("FAIL reset_cnt: got %h expected %h", {stall_cnt, flush_cnt}, 32'h0);
    else n_pass++;
    n_total++;
    if (obs_comb() !== 7'b100_00_00)
      $display("FAIL reset_idle_comb: got %b expected %b", obs_comb(), 7'b100_00_00);
    else n_pass++;
  endtask

  task automatic test_forward_priority();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11;
    do_reset();
    drs = 5'd5; ern = 5'd5; ewreg = 1; em2reg = 0; mrn = 5'd5; mwreg = 1; mm2reg = 0;
    drt = 5'd9;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ewreg = 0;
      if (i == 2) mm2reg = 1;
      #1;
      n_total++;
      if (fwda !== want[i] || fwdb !== 2'b00)
        $display("FAIL fwd_prio_%0d: got fwda=%b fwdb=%b expected fwda=%b fwdb=00",
                 i, fwda, fwdb, want[i]);
      else n_pass++;
    end
    // Mirror on rt
    drt = 5'd5; drs = 5'd0;
    #1;
    n_total++;
    if (fwdb !== 2'b11 || fwda !== 2'b00)
      $display("FAIL fwd_rt: got fwda=%b fwdb=%b expected fwda=00 fwdb=11", fwda, fwdb);
    else n_pass++;
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drt = 5'd7; duse_rt = 1; ern = 5'd7; ewreg = 1; em2reg = 1;
    #1;
    n_total++;
    if ({wpcir, de_clear, fd_clear} !== 3'b010)
      $display("FAIL load_use_t: got %b expected %b", {wpcir, de_clear, fd_clear}, 3'b010);
    else n_pass++;
    tick();
    n_total++;
    if ({wpcir, de_clear, fd_clear} !== 3'b100)
      $display("FAIL load_use_t1: got %b expected %b", {wpcir, de_clear, fd_clear}, 3'b100);
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd1)
      $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
    else n_pass++;
    tick();
    // Back in RUN: held hazard stalls again
    n_total++;
    if ({wpcir, de_clear} !== 2'b01)
      $display("FAIL load_use_t2: got %b expected %b", {wpcir, de_clear}, 2'b01);
    else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    drt = 5'd7; duse_rt = 1; ern = 5'd7; ewreg = 1; em2reg = 1; eredirect = 1;
    #1;
    n_total++;
    if ({wpcir, fd_clear, de_clear} !== 3'b111)
      $display("FAIL redirect_comb: got %b expected %b", {wpcir, fd_clear, de_clear}, 3'b111);
    else n_pass++;
    tick();
    eredirect = 0; ewreg = 0;
    n_total++;
    if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1})
      $display("FAIL redirect_cnt: got stall=%0d flush=%0d expected stall=0 flush=1",
               stall_cnt, flush_cnt);
    else n_pass++;
    idle();
  endtask

  task automatic test_reg_zero();
    do_reset();
    drs = 5'd0; duse_rs = 1; ern = 5'd0; ewreg = 1; em2reg = 1; mrn = 5'd0; mwreg = 1;
    #1;
    n_total++;
    if ({fwda, wpcir, de_clear} !== 4'b00_10)
      $display("FAIL reg_zero: got %b expected %b", {fwda, wpcir, de_clear}, 4'b00_10);
    else n_pass++;
    em2reg = 0;
    #1;
    n_total++;
    if (fwda !== 2'b00)
      $display("FAIL reg_zero_fwd: got %b expected 00", fwda);
    else n_pass++;
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      drs       = 5'($urandom_range(0, 3));
      drt       = 5'($urandom_range(0, 3));
      ern       = 5'($urandom_range(0, 3));
      mrn       = 5'($urandom_range(0, 3));
      duse_rs   = 1'($urandom);
      duse_rt   = 1'($urandom);
      ewreg     = ($urandom_range(0, 3) != 0);
      em2reg    = 1'($urandom);
      mwreg     = 1'($urandom);
      mm2reg    = 1'($urandom);
      eredirect = ($urandom_range(0, 7) == 0);
      #1;
      n_total++;
      if (obs_comb() !== exp_comb())
        $display("FAIL rand_comb_%0d: got %b expected %b", i, obs_comb(), exp_comb());
      else n_pass++;
      tick();
      n_total++;
      if ({stall_cnt, flush_cnt} !== exp_cnt())
        $display("FAIL rand_cnt_%0d: got %h expected %h", i, {stall_cnt, flush_cnt},
                 exp_cnt());
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    eredirect = 1;
    repeat (65534) tick();
    n_total++;
    if (flush_cnt !== 16'hFFFE)
      $display("FAIL sat_pre: got %h expected %h", flush_cnt, 16'hFFFE);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (flush_cnt !== 16'hFFFF)
      $display("FAIL sat_flush: got %h expected %h", flush_cnt, 16'hFFFF);
    else n_pass++;
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    eredirect = 1;
    tick();
    eredirect = 0;
    drs = 5'd4; duse_rs = 1; ern = 5'd4; ewreg = 1; em2reg = 1;
    tick();  // now in BUBBLE
    rst_n = 0;
    #1;
    n_total++;
    if ({wpcir, fd_clear, de_clear} !== 3'b111)
      $display("FAIL rst_stall_comb: got %b expected %b", {wpcir, fd_clear, de_clear},
               3'b111);
    else n_pass++;
    tick();
    rst_n = 1;
    #1;
    n_total++;
    if ({stall_cnt, flush_cnt} !== 32'h0)
      $display("FAIL rst_stall_cnt: got %h expected %h", {stall_cnt, flush_cnt}, 32'h0);
    else n_pass++;
    n_total++;
    if ({wpcir, de_clear} !== 2'b01)
      $display("FAIL rst_stall_run: got %b expected %b", {wpcir, de_clear}, 2'b01);
    else n_pass++;
    tick();
    n_total++;
    if (stall_cnt !== 16'd1)
      $display("FAIL rst_stall_after: got %0d expected 1", stall_cnt);
    else n_pass++;
    idle();
  endtask

  initial begin
    idle();
    m_bubble = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    test_reset();
    test_forward_priority();
    test_load_use();
    test_redirect_load_use();
    test_reg_zero();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
